// File: rtl/uart_packet_tx_if.sv
// Request/byte-stream bundle between the frame source, the sequencer and the UART TX core.
interface uart_packet_tx_if #(
    parameter int unsigned PAYLOAD_BYTES = 3
) ();
    logic                         send;
    logic [7:0]                   board_id;
    logic [8*PAYLOAD_BYTES-1:0]   payload;
    logic                         tx_ready;
    logic [7:0]                   tx_data;
    logic                         tx_valid;
    logic                         busy;
    logic                         done;
    logic                         dropped;

    // Frame source plus UART side (drives requests and tx_ready).
    modport master (
        output send, board_id, payload, tx_ready,
        input  tx_data, tx_valid, busy, done, dropped
    );

    // The sequencer itself.
    modport slave (
        input  send, board_id, payload, tx_ready,
        output tx_data, tx_valid, busy, done, dropped
    );
endinterface

// File: rtl/uart_packet_tx.sv
// Frames board ID + payload (+ optional mod-256 checksum) into a byte stream for the UART TX core.
module uart_packet_tx #(
    parameter int unsigned PAYLOAD_BYTES = 3,
    parameter bit          SEND_CHECKSUM = 1'b1,
    parameter logic [7:0]  IDLE_BYTE     = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    uart_packet_tx_if.slave  bus
);
    localparam int unsigned PW = 8 * PAYLOAD_BYTES;
    localparam int unsigned CW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ID      = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CSUM    = 2'd3
    } state_t;

    state_t          r_state,   w_state_nxt;
    logic [CW-1:0]   r_cnt,     w_cnt_nxt;
    logic [PW-1:0]   r_snap_pl, w_snap_nxt;
    logic [7:0]      r_csum,    w_csum_nxt;
    logic [7:0]      r_tx_data, w_data_nxt;
    logic            r_tx_valid, w_valid_nxt;
    logic            r_busy,    w_busy_nxt;
    logic            r_done,    w_done_nxt;
    logic            r_dropped, w_dropped_nxt;

    logic            w_xfer;
    logic [7:0]      w_csum_sum;
    logic [7:0]      w_next_byte;

    assign w_xfer      = r_tx_valid & bus.tx_ready;
    assign w_csum_sum  = r_csum + r_tx_data;
    assign w_next_byte = r_snap_pl[PW-1 -: 8];

    assign bus.tx_data  = r_tx_data;
    assign bus.tx_valid = r_tx_valid;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.dropped  = r_dropped;

    // State and output registers; synchronous reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_snap_pl  <= '0;
            r_csum     <= 8'h00;
            r_tx_data  <= IDLE_BYTE;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dropped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_snap_pl  <= w_snap_nxt;
            r_csum     <= w_csum_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_valid <= w_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_dropped  <= w_dropped_nxt;
        end
    end

    // Next-state/output logic; the snapshot shifts left so its top byte is always the next payload byte.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_snap_nxt    = r_snap_pl;
        w_csum_nxt    = r_csum;
        w_data_nxt    = r_tx_data;
        w_valid_nxt   = r_tx_valid;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_dropped_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.send) begin
                    if (bus.board_id != 8'h00) begin
                        w_snap_nxt  = bus.payload;
                        w_csum_nxt  = 8'h00;
                        w_cnt_nxt   = '0;
                        w_data_nxt  = bus.board_id;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_ID;
                    end else begin
                        w_dropped_nxt = 1'b1;
                    end
                end
            end

            S_ID: begin
                w_dropped_nxt = bus.send;
                if (w_xfer) begin
                    w_csum_nxt  = w_csum_sum;
                    w_data_nxt  = w_next_byte;
                    w_snap_nxt  = r_snap_pl << 8;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PAYLOAD;
                end
            end

            S_PAYLOAD: begin
                w_dropped_nxt = bus.send;
                if (w_xfer) begin
                    w_csum_nxt = w_csum_sum;
                    if (r_cnt != LAST_CNT) begin
                        w_cnt_nxt  = r_cnt + CW'(1);
                        w_data_nxt = w_next_byte;
                        w_snap_nxt = r_snap_pl << 8;
                    end else if (SEND_CHECKSUM) begin
                        w_cnt_nxt   = '0;
                        w_data_nxt  = w_csum_sum;
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_csum_nxt  = 8'h00;
                        w_data_nxt  = IDLE_BYTE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_CSUM: begin
                w_dropped_nxt = bus.send;
                if (w_xfer) begin
                    w_cnt_nxt   = '0;
                    w_csum_nxt  = 8'h00;
                    w_data_nxt  = IDLE_BYTE;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_packet_tx.sv
// Randomised + directed bench for uart_packet_tx against a queue-based frame model.
`timescale 1ns/1ps
module tb_uart_packet_tx;
    logic clk;
    logic rst;

    uart_packet_tx_if #(.PAYLOAD_BYTES(3)) ifa ();
    uart_packet_tx_if #(.PAYLOAD_BYTES(1)) ifb ();

    uart_packet_tx #(.PAYLOAD_BYTES(3), .SEND_CHECKSUM(1'b1), .IDLE_BYTE(8'hFF)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    uart_packet_tx #(.PAYLOAD_BYTES(1), .SEND_CHECKSUM(1'b0), .IDLE_BYTE(8'hFF)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // Model: the bytes of the current frame still to be transferred (head = byte on offer).
    logic [7:0] m_q[$];
    logic [7:0] m_last[$];
    bit         m_done;
    bit         m_dropped;
    logic [7:0] act_log[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frame(input logic [7:0] id, input logic [23:0] pl);
        int sum;
        logic [7:0] b;
        m_q.delete();
        m_q.push_back(id);
        sum = int'(id);
        for (int i = 0; i < 3; i++) begin
            b = pl[8*(2-i) +: 8];
            m_q.push_back(b);
            sum += int'(b);
        end
        m_q.push_back(8'(sum % 256));
        m_last = m_q;
    endtask

    // Frame-level model update on each clock edge from the bench-driven inputs.
    always @(posedge clk) begin
        m_done    = 1'b0;
        m_dropped = 1'b0;
        if (rst) begin
            m_q.delete();
        end else if (m_q.size() != 0) begin
            if (ifa.send) m_dropped = 1'b1;
            if (ifa.tx_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (ifa.send) begin
            if (ifa.board_id == 8'h00) m_dropped = 1'b1;
            else build_frame(ifa.board_id, ifa.payload);
        end
    end

    // Per-cycle comparison of DUT A against the model, plus a log of transferred bytes.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid",   32'(ifa.tx_valid), 32'(m_q.size() != 0));
            chk("busy",    32'(ifa.busy),     32'(m_q.size() != 0));
            chk("data",    32'(ifa.tx_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'hFF);
            chk("done",    32'(ifa.done),     32'(m_done));
            chk("dropped", 32'(ifa.dropped),  32'(m_dropped));
            if (ifa.tx_valid && ifa.tx_ready) act_log.push_back(ifa.tx_data);
        end
    end

    task automatic chk_log(input string nm, input logic [39:0] exp);
        logic [31:0] a;
        chk({nm, "_len"}, 32'(act_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            a = (i < act_log.size()) ? 32'(act_log[i]) : 32'hDEAD;
            chk(nm, a, 32'(exp[8*(4-i) +: 8]));
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (ifa.done) seen = 1'b1;
        end
        chk({nm, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic start_a(input logic [7:0] id, input logic [23:0] pl);
        ifa.board_id = id;
        ifa.payload  = pl;
        ifa.send     = 1'b1;
        tick();
        ifa.send     = 1'b0;
    endtask

    initial begin
        bit tog;
        int stall;
        bit seen;

        rst = 1'b1;
        ifa.send = 1'b0; ifa.board_id = 8'h00; ifa.payload = '0; ifa.tx_ready = 1'b1;
        ifb.send = 1'b0; ifb.board_id = 8'h00; ifb.payload = '0; ifb.tx_ready = 1'b1;
        repeat (3) tick();
        chk("rst_data",  32'(ifa.tx_data),  32'hFF);
        chk("rst_valid", 32'(ifa.tx_valid), 32'h0);
        chk("rst_busy",  32'(ifa.busy),     32'h0);
        rst = 1'b0;
        chk_on = 1'b1;
        tick();

        // 1: nominal frame, one-cycle latency, done pulse.
        act_log.delete();
        start_a(8'h05, 24'h123456);
        chk("t1_first_valid", 32'(ifa.tx_valid), 32'h1);
        chk("t1_first_data",  32'(ifa.tx_data),  32'h05);
        repeat (5) tick();
        chk("t1_done", 32'(ifa.done),    32'h1);
        chk("t1_busy", 32'(ifa.busy),    32'h0);
        chk("t1_idle", 32'(ifa.tx_data), 32'hFF);
        chk("t1_model_csum", 32'(m_last[4]), 32'hA1);
        tick();
        chk("t1_done_pulse", 32'(ifa.done), 32'h0);
        chk_log("t1_bytes", 40'h05_12_34_56_A1);

        // 2: toggling ready with a 5-cycle stall on 0x34.
        act_log.delete();
        start_a(8'h05, 24'h123456);
        tog = 1'b1; stall = 0; seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (ifa.tx_valid && ifa.tx_data == 8'h34 && stall < 5) begin
                ifa.tx_ready = 1'b0;
                stall++;
            end else begin
                ifa.tx_ready = tog;
                tog = ~tog;
            end
            tick();
            if (ifa.done) seen = 1'b1;
        end
        chk("t2_timeout", 32'(seen), 32'd1);
        chk_log("t2_bytes", 40'h05_12_34_56_A1);
        ifa.tx_ready = 1'b1;
        tick();

        // 3: unconfigured board ID is dropped.
        ifa.board_id = 8'h00;
        ifa.send = 1'b1;
        tick();
        ifa.send = 1'b0;
        chk("t3_dropped", 32'(ifa.dropped),  32'h1);
        chk("t3_valid",   32'(ifa.tx_valid), 32'h0);
        chk("t3_data",    32'(ifa.tx_data),  32'hFF);
        chk("t3_busy",    32'(ifa.busy),     32'h0);
        tick();
        chk("t3_drop_pulse", 32'(ifa.dropped), 32'h0);

        // 4: send while busy with changed payload leaves the frame intact.
        act_log.delete();
        start_a(8'h05, 24'h123456);
        tick();
        ifa.payload = 24'hFFFFFF;
        ifa.send = 1'b1;
        tick();
        ifa.send = 1'b0;
        chk("t4_dropped", 32'(ifa.dropped), 32'h1);
        wait_done("t4", 20);
        chk_log("t4_bytes", 40'h05_12_34_56_A1);
        tick();

        // 5: checksum wrap-around, then reset mid-frame and a fresh frame.
        act_log.delete();
        start_a(8'hFF, 24'hFFFFFF);
        wait_done("t5a", 20);
        chk_log("t5_wrap", 40'hFF_FF_FF_FF_FC);
        chk("t5_model_csum", 32'(m_last[4]), 32'hFC);
        tick();
        start_a(8'h05, 24'h123456);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_valid", 32'(ifa.tx_valid), 32'h0);
        chk("t5_rst_data",  32'(ifa.tx_data),  32'hFF);
        chk("t5_rst_busy",  32'(ifa.busy),     32'h0);
        act_log.delete();
        start_a(8'h05, 24'h123456);
        chk("t5_restart_id", 32'(ifa.tx_data), 32'h05);
        wait_done("t5b", 20);
        chk_log("t5_restart", 40'h05_12_34_56_A1);

        // Randomised traffic including occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst          = ($urandom_range(0, 249) == 0);
            ifa.send     = ($urandom_range(0, 5) == 0);
            ifa.board_id = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ifa.payload  = 24'($urandom);
            ifa.tx_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b0; ifa.send = 1'b0; ifa.tx_ready = 1'b1;
        repeat (10) tick();

        // 6: one-byte payload without checksum, back-to-back frame from the done cycle.
        ifb.board_id = 8'h0A;
        ifb.payload  = 8'h7E;
        ifb.send     = 1'b1;
        tick();
        ifb.send     = 1'b0;
        chk("t6_id_valid", 32'(ifb.tx_valid), 32'h1);
        chk("t6_id",       32'(ifb.tx_data),  32'h0A);
        tick();
        chk("t6_payload",  32'(ifb.tx_data),  32'h7E);
        tick();
        chk("t6_done",     32'(ifb.done),     32'h1);
        chk("t6_valid0",   32'(ifb.tx_valid), 32'h0);
        chk("t6_idle",     32'(ifb.tx_data),  32'hFF);
        chk("t6_busy0",    32'(ifb.busy),     32'h0);
        ifb.board_id = 8'h0B;
        ifb.payload  = 8'h3C;
        ifb.send     = 1'b1;
        tick();
        ifb.send     = 1'b0;
        chk("t6_b2b_id",   32'(ifb.tx_data),  32'h0B);
        chk("t6_b2b_nodrop", 32'(ifb.dropped), 32'h0);
        tick();
        chk("t6_b2b_pl",   32'(ifb.tx_data),  32'h3C);
        tick();
        chk("t6_b2b_done", 32'(ifb.done),     32'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
